carry_resolve_seq: RTL and testbench

CARRY_RESOLVE_SEQ -- requirements
Module: carry_resolve_seq

---
 rtl/carry_resolve_seq.sv | 75 +++++++
 tb/tb_carry_resolve_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carry_resolve_seq.sv
// carry_resolve_seq: resolves a 64-bit carry-save pair (s, c) into a binary sum
// by iterating s^c / (s&c)<<1 until no carry remains, with valid/ready at both ends.
module carry_resolve_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_s,
    input  logic [63:0] in_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_sum,
    output logic        out_cout,
    output logic [6:0]  out_iters
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RESOLVE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    logic [1:0]  state;
    logic [63:0] s;
    logic [63:0] c;
    logic        cout;
    logic [6:0]  iters;
    logic        hold;

    // Accept an operand pair, ripple one carry step per cycle, then hold the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s     <= '0;
            c     <= '0;
            cout  <= 1'b0;
            iters <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s     <= in_s;
                        c     <= in_c;
                        cout  <= 1'b0;
                        iters <= '0;
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    if (c == '0) begin
                        state <= HOLD;
                    end else begin
                        s     <= s ^ c;
                        c     <= {s[62:0] & c[62:0], 1'b0};
                        cout  <= cout | (s[63] & c[63]);
                        iters <= iters + 7'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registered state only; results are masked outside HOLD.
    assign hold      = (state == HOLD);
    assign in_ready  = (state == IDLE);
    assign out_valid = hold;
    assign out_sum   = hold ? s : '0;
    assign out_cout  = hold & cout;
    assign out_iters = hold ? iters : '0;

endmodule

// File: tb/tb_carry_resolve_seq.sv
// tb_carry_resolve_seq: directed table, handshake/reset sequences and
// random operand pairs checked against 65-bit arithmetic.
module tb_carry_resolve_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_s;
    logic [63:0] in_c;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_sum;
    logic        out_cout;
    logic [6:0]  out_iters;

    int total;
    int bad;

    carry_resolve_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_iters (out_iters)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [63:0] s;
        logic [63:0] c;
        logic [63:0] sum;
        logic        cout;
        int          iters;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge. Returns the presented result and the number of
    // edges from the accept edge to the edge that raised out_valid.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] sum, output logic co,
                          output logic [6:0] it, output int lat);
        int guard;
        logic quiet;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("accept_ready", in_ready, 1);
        in_valid = 1'b1;
        in_s = a;
        in_c = b;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        quiet = 1'b1;
        while (!out_valid && lat < 200) begin
            if (out_sum !== 0 || out_cout !== 0 || out_iters !== 0 ||
                in_ready !== 0)
                quiet = 1'b0;
            in_valid = 1'($urandom);
            in_s = {$urandom, $urandom};
            in_c = {$urandom, $urandom};
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("resolve_quiet", quiet, 1);
        in_valid = 1'b0;
        sum = out_sum;
        co = out_cout;
        it = out_iters;
        if (!out_valid) begin
            check("valid_timeout", out_valid, 1);
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
        end else begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check("release_idle", {out_valid, in_ready}, 2'b01);
        end
    endtask

    vec_t        vecs[7];
    logic [63:0] r_sum;
    logic        r_co;
    logic [6:0]  r_it;
    int          r_lat;
    logic [63:0] a;
    logic [63:0] b;
    logic [64:0] ref65;
    logic [63:0] h_sum;
    logic        h_co;
    logic [6:0]  h_it;
    logic        stable;

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_s = '0;
        in_c = '0;
        out_ready = 1'b0;

        vecs[0] = '{64'h5, 64'h0, 64'h5, 1'b0, 0};
        vecs[1] = '{64'h3, 64'h1, 64'h4, 1'b0, 3};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 64};
        vecs[3] = '{64'h0, 64'h0, 64'h0, 1'b0, 0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 2};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h0, 1'b1, 1};
        vecs[6] = '{64'hF0, 64'h10, 64'h100, 1'b0, 5};

        @(negedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        check("rst_iters", out_iters, 0);
        check("rst_ready", in_ready, 1);
        rst = 1'b0;

        // Directed table; first entry is accepted on the first edge after reset.
        foreach (vecs[i]) begin
            run_op(vecs[i].s, vecs[i].c, r_sum, r_co, r_it, r_lat);
            check($sformatf("vec%0d_sum", i), r_sum, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), r_co, vecs[i].cout);
            check($sformatf("vec%0d_iters", i), r_it, vecs[i].iters);
            check($sformatf("vec%0d_lat", i), r_lat, vecs[i].iters + 1);
        end

        // Backpressure: HOLD with out_ready low while in_valid toggles.
        in_valid = 1'b1;
        in_s = 64'h3;
        in_c = 64'h1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !out_valid; n++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("hold_valid", out_valid, 1);
        h_sum = 64'h4;
        h_co = 1'b0;
        h_it = 7'd3;
        stable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            in_valid = ~in_valid;
            in_s = {$urandom, $urandom};
            in_c = {$urandom, $urandom};
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1 || out_sum !== h_sum || out_cout !== h_co ||
                out_iters !== h_it || in_ready !== 0)
                stable = 1'b0;
        end
        check("hold_stable", stable, 1);
        in_valid = 1'b1;
        in_s = 64'h7;
        in_c = 64'h0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("hold_exit_idle", {out_valid, in_ready}, 2'b01);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("late_accept_busy", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        check("late_accept_valid", out_valid, 1);
        check("late_accept_sum", out_sum, 64'h7);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset at iteration 10 of the all-ones case.
        in_valid = 1'b1;
        in_s = 64'hFFFF_FFFF_FFFF_FFFF;
        in_c = 64'h1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_sum", out_sum, 0);
        check("midrst_cout", out_cout, 0);
        check("midrst_iters", out_iters, 0);
        check("midrst_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(64'h1, 64'h1, r_sum, r_co, r_it, r_lat);
        check("postrst_sum", r_sum, 64'h2);
        check("postrst_cout", r_co, 0);
        check("postrst_iters", r_it, 2);

        // Random pairs against 65-bit addition.
        for (int n = 0; n < 10000; n++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom % 8)
                2, 3: b = 64'h1 << ($urandom % 64);
                4: b = '0;
                5: a = '0;
                6, 7: b = b & {$urandom, $urandom} & {$urandom, $urandom};
                default: ;
            endcase
            ref65 = {1'b0, a} + {1'b0, b};
            run_op(a, b, r_sum, r_co, r_it, r_lat);
            check("rnd_sum", r_sum, ref65[63:0]);
            check("rnd_cout", r_co, ref65[64]);
            check("rnd_iters_le_64", r_it <= 7'd64, 1);
            check("rnd_lat", r_lat, r_it + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
